// File: rtl/lsu_types.sv
// Load/store unit FSM states and access-size encodings (size = funct3[1:0]).
package lsu_types;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE0, S_WAIT0, S_ISSUE1, S_WAIT1, S_DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_t;

  function automatic logic [2:0] size_bytes(lsu_size_t s);
    case (s)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_defines.sv
// RV32I funct3 encodings for the load and store instructions.
package rv32i_defines;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane enables, store lane shifting and load merge/shift/extend.
// second_i selects the upper half of the 8-lane window spanning two words.
module lsu_lane_align
  import lsu_types::*;
(
  input  logic [1:0]  off_i,
  input  lsu_size_t   size_i,
  input  logic        unsigned_i,
  input  logic        second_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word0_i,
  input  logic [31:0] ld_word1_i,
  output logic [3:0]  byte_ena_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  lane_mask;
  logic [2:0]  nbytes;
  logic [63:0] st_wide, ld_wide;
  logic [31:0] ld_sh;

  assign nbytes = size_bytes(size_i);

  for (genvar l = 0; l < 8; l++) begin : g_lane
    assign lane_mask[l] = (4'(l) >= {2'b00, off_i}) &&
                          (4'(l) <  ({2'b00, off_i} + {1'b0, nbytes}));
  end

  assign byte_ena_o = second_i ? lane_mask[7:4] : lane_mask[3:0];
  assign st_wide    = {32'b0, st_data_i} << {off_i, 3'b000};
  assign st_data_o  = second_i ? st_wide[63:32] : st_wide[31:0];
  assign ld_wide    = {ld_word1_i, ld_word0_i} >> {off_i, 3'b000};
  assign ld_sh      = ld_wide[31:0];

  always_comb begin
    case (size_i)
      BYTE:    ld_data_o = {{24{~unsigned_i & ld_sh[7]}},  ld_sh[7:0]};
      HALF:    ld_data_o = {{16{~unsigned_i & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/rv32i_load_store_unit.sv
// RV32I load/store unit: byte/half/word accesses onto a word-addressed sync RAM.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses instead of faulting.
module rv32i_load_store_unit
  import rv32i_defines::*;
  import lsu_types::*;
#(
  parameter int READ_LATENCY = 1,
  parameter bit PAD_SE       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_byte_ena,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data
);

  if (!PAD_SE) begin : g_pad_se_reserved
  end

  lsu_state_t  state_q, state_d;
  logic        we_q, fault_q, split_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wd_q, stage_q, stage_d, rd_q, rd_d;
  logic [1:0]  cnt_q, cnt_d;

  lsu_size_t   size_in;
  logic        illegal_in, misal_in, fault_in, split_in, last, issue, second;
  logic [3:0]  ena;
  logic [31:0] st_data, ld_data, ld_word0;

  assign size_in    = lsu_size_t'(funct3[1:0]);
  assign illegal_in = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) ||
                      (we && !(funct3 inside {F3_SB, F3_SH, F3_SW}));

  always_comb begin
    case (size_in)
      HALF:    misal_in = addr[0];
      WORD:    misal_in = |addr[1:0];
      default: misal_in = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign fault_in = illegal_in;
  assign split_in = !illegal_in &&
                    (({1'b0, addr[1:0]} + size_bytes(size_in)) > 3'd4);
`else
  assign fault_in = illegal_in | misal_in;
  assign split_in = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign last = (cnt_q == 2'(READ_LATENCY - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) state_d = fault_in ? S_DONE : S_ISSUE0;
      S_ISSUE0: state_d = !we_q ? S_WAIT0 : (split_q ? S_ISSUE1 : S_DONE);
      S_WAIT0:  if (last) state_d = split_q ? S_ISSUE1 : S_DONE;
      S_ISSUE1: state_d = we_q ? S_DONE : S_WAIT1;
      S_WAIT1:  if (last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: request latch, latency counter, staging word, load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q <= 1'b0; f3_q <= '0; addr_q <= '0; wd_q <= '0;
      fault_q <= 1'b0; split_q <= 1'b0;
      cnt_q <= '0; stage_q <= '0; rd_q <= '0;
    end else begin
      if (state_q == S_IDLE && req) begin
        we_q <= we; f3_q <= funct3; addr_q <= addr; wd_q <= wr_data;
        fault_q <= fault_in; split_q <= split_in;
      end
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rd_q    <= rd_d;
    end
  end

  assign ld_word0 = (state_q == S_WAIT1) ? stage_q : mem_rd_data;

  always_comb begin
    cnt_d   = '0;
    stage_d = stage_q;
    rd_d    = rd_q;
    if ((state_q == S_WAIT0 || state_q == S_WAIT1) && !last) cnt_d = cnt_q + 2'd1;
    if (state_q == S_WAIT0 && last) stage_d = mem_rd_data;
    // Final read word arrives in the last wait cycle; commit so rd_data is valid with done.
    if (last && ((state_q == S_WAIT0 && !split_q) || state_q == S_WAIT1)) rd_d = ld_data;
  end

  assign second = (state_q == S_ISSUE1);

  lsu_lane_align u_align (
    .off_i      (addr_q[1:0]),
    .size_i     (lsu_size_t'(f3_q[1:0])),
    .unsigned_i (f3_q[2]),
    .second_i   (second),
    .st_data_i  (wd_q),
    .ld_word0_i (ld_word0),
    .ld_word1_i (mem_rd_data),
    .byte_ena_o (ena),
    .st_data_o  (st_data),
    .ld_data_o  (ld_data)
  );

  assign issue = (state_q == S_ISSUE0) || second;

  always_comb begin
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    done         = (state_q == S_DONE);
    fault        = done && fault_q;
    rd_data      = rd_q;
    mem_addr     = '0;
    mem_wr_data  = '0;
    mem_byte_ena = '0;
    mem_wr_ena   = 1'b0;
    if (issue) begin
      mem_addr     = {addr_q[31:2] + {29'b0, second}, 2'b00};
      mem_byte_ena = ena;
      mem_wr_ena   = we_q;
      mem_wr_data  = we_q ? st_data : '0;
    end
  end

endmodule

// File: doc/rv32i_load_store_unit.md
Name: rv32i_load_store_unit

Overview:
Downstream neighbour of the multicycle RV32I core. It sits between the core's data-memory request and a 32-bit word-addressed synchronous RAM.
- Converts byte, halfword and word loads and stores into word accesses with byte enables.
- Sign- or zero-extends load data.
- Splits misaligned accesses into two word accesses (optional feature); otherwise it flags them as faults.
- Exposes a req/busy/done handshake so the core's FSM can stall in its memory states.

Parameters:
- READ_LATENCY, 1: cycles from address issue to valid mem_rd_data. Legal range 1..3.
- PAD_SE, 1: reserved. Tie to 1 and ignore in logic.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Asynchronous, active-high.
- req  in  1  access request, sampled only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- addr  in  32  byte address
- wr_data  in  32  store data, right-aligned
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done: illegal funct3, or misaligned access with the feature off
- rd_data  out  32  extended load result. Registered; holds until the next load completes.
- mem_addr  out  32  word-aligned address, bits [1:0] always 00
- mem_wr_data  out  32  lane-shifted store data
- mem_byte_ena  out  4  byte lane enables
- mem_wr_ena  out  1  write strobe, high only in ISSUE states of a store
- mem_rd_data  in  32  RAM read word

Behaviour:
Reset:
- State goes to IDLE.
- All outputs reset to 0, including rd_data.
- Reset mid-operation abandons the access. A half-done split store is not retried.

FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
- IDLE, req=1:
  - Latch we, funct3, addr, wr_data.
  - Illegal funct3 (011, 110, 111, or store with funct3[2]=1) → DONE with fault=1, no memory access.
  - Otherwise → ISSUE0.
  - req while not IDLE is ignored.
- ISSUE0 (one cycle):
  - mem_addr = {addr[31:2],2'b00}.
  - mem_byte_ena = lanes addr[1:0]..min(addr[1:0]+size-1, 3).
  - Store: mem_wr_data = wr_data << 8*addr[1:0], mem_wr_ena=1. Then → ISSUE1 if split, else DONE.
  - Load: → WAIT0.
- WAIT0:
  - Counter runs READ_LATENCY-1 extra cycles.
  - mem_rd_data is captured at issue+READ_LATENCY into a 32-bit staging register.
  - Then → ISSUE1 if split, else DONE.
- ISSUE1 / WAIT1:
  - Address is addr+4, word-aligned; wraps 0xFFFFFFFC→0x00000000.
  - Lanes 0..(addr[1:0]+size-5).
  - Store data is wr_data >> 8*(4-addr[1:0]).
- DONE (one cycle):
  - done=1, busy=0, then → IDLE.
  - For a load, rd_data is updated in this cycle: merge the staging word(s), shift right by 8*addr[1:0], mask to size, then sign-extend (funct3[2]=0) or zero-extend.
  - A new req is accepted only in the IDLE cycle after DONE.

Latency, with T = cycle req is sampled:
- Aligned store: done at T+2.
- Aligned load: done at T+2+READ_LATENCY.
- Split access: adds 1 (store) or 1+READ_LATENCY (load).
- Fault: done at T+1.

Memory outputs are 0 whenever the state is not ISSUE*.

Optional Feature:
Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: a misaligned access spanning two words (LH/SH at offset 3; LW/SW at offset 1..3) is split into two accesses as above. fault is raised only for illegal funct3.
- Undefined: any access with addr not aligned to its size goes IDLE→DONE with fault=1, no memory activity, and rd_data unchanged. ISSUE1/WAIT1 are not synthesised.

Decomposition:
- lsu_types.sv package holds lsu_state_t (the six states) and the size encodings BYTE/HALF/WORD derived from funct3[1:0].
- RV32I funct3 load/store constants are added to rv32i_defines.sv.
- One combinational sub-module, lsu_lane_align, holds the byte-lane enable generation, store shifting, and load merge/shift/extend. The FSM stays in the top module.

Test Plan:
- LW addr=0x100, RAM[0x100]=0xDEADBEEF, READ_LATENCY=1 → one issue at 0x100 with byte_ena=1111; done at T+3; rd_data=0xDEADBEEF; fault=0.
- LB addr=0x103 with that word → byte_ena=1000, rd_data=0xFFFFFFDE. LBU → 0x000000DE.
- SH addr=0x102 wr_data=0x0000ABCD → mem_wr_data=0xABCD0000, byte_ena=1100, mem_wr_ena high exactly one cycle, done at T+2.
- LW addr=0x101 with split enabled, RAM[0x100]=0x44332211, RAM[0x104]=0x88776655 → issues at 0x100 then 0x104; rd_data=0x55443322. With split disabled → no issue, done at T+1, fault=1.
- funct3=011 load → fault=1 at T+1, no memory activity. Then assert rst during WAIT0 of a LW → all outputs 0 immediately, next req accepted normally.
- READ_LATENCY=3 LHU addr=0x0FE with RAM[0x0FC]=0x80010000 → done at T+5, rd_data=0x00008001.
